// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: stage enables/clears for a 5-stage MIPS-style pipe,
// load-use and branch-operand stalls, memory/fetch wait stalls, and a 32-cycle divide FSM.
module pipe_hazard_ctrl (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] RsD,
  input  logic [4:0] RtD,
  input  logic       BranchD,
  input  logic       RegWriteE,
  input  logic       MemToRegE,
  input  logic [4:0] WriteRegE,
  input  logic       MemToRegM,
  input  logic [4:0] WriteRegM,
  input  logic       DivStartE,
  input  logic       InstReqF,
  input  logic       InstOkF,
  input  logic       DataReqM,
  input  logic       DataOkM,
  input  logic       ExceptionM,
  output logic       EnF,
  output logic       EnD,
  output logic       EnE,
  output logic       EnM,
  output logic       EnW,
  output logic       ClrD,
  output logic       ClrE,
  output logic       ClrM,
  output logic       ClrW,
  output logic       DivGo,
  output logic       DivAbort,
  output logic       DivBusy
);

  localparam logic [5:0] DivCycles = 6'd32;

  typedef enum logic [1:0] {
    StIdle,
    StDiv,
    StDivDone
  } state_e;

  state_e     state_q, state_d;
  logic [5:0] div_cnt_q, div_cnt_d;

  logic mem_stall;
  logic fetch_stall;
  logic e_matches_src;
  logic m_matches_src;
  logic load_use;
  logic br_haz;

  // Hazard detection; register 0 is hard-wired and never forms a dependency.
  always_comb begin
    mem_stall     = DataReqM & ~DataOkM;
    fetch_stall   = InstReqF & ~InstOkF;
    e_matches_src = (WriteRegE != 5'd0) & ((WriteRegE == RsD) | (WriteRegE == RtD));
    m_matches_src = (WriteRegM != 5'd0) & ((WriteRegM == RsD) | (WriteRegM == RtD));
    load_use      = MemToRegE & RegWriteE & e_matches_src;
    br_haz        = BranchD & ((RegWriteE & e_matches_src) | (MemToRegM & m_matches_src));
  end

  always_comb begin
    state_d   = state_q;
    div_cnt_d = div_cnt_q;

    EnF      = 1'b1;
    EnD      = 1'b1;
    EnE      = 1'b1;
    EnM      = 1'b1;
    EnW      = 1'b1;
    ClrD     = 1'b0;
    ClrE     = 1'b0;
    ClrM     = 1'b0;
    ClrW     = 1'b0;
    DivGo    = 1'b0;
    DivAbort = 1'b0;

    // Divider progression runs even under a memory stall; only DIV_DONE waits for it.
    case (state_q)
      StDiv: begin
        div_cnt_d = div_cnt_q - 6'd1;
        if (div_cnt_q == 6'd1) begin
          state_d = StDivDone;
        end
      end
      StDivDone: begin
        if (!mem_stall) begin
          state_d = StIdle;
        end
      end
      default: ;
    endcase

    if (ExceptionM) begin
      EnF  = 1'b1;
      ClrD = 1'b1;
      ClrE = 1'b1;
      ClrM = 1'b1;
      if (state_q != StIdle) begin
        DivAbort  = 1'b1;
        state_d   = StIdle;
        div_cnt_d = 6'd0;
      end
    end else if (mem_stall) begin
      EnF  = 1'b0;
      EnD  = 1'b0;
      EnE  = 1'b0;
      EnM  = 1'b0;
      ClrW = 1'b1;
    end else if (state_q == StDiv) begin
      EnF  = 1'b0;
      EnD  = 1'b0;
      EnE  = 1'b0;
      ClrM = 1'b1;
    end else if ((state_q == StIdle) && DivStartE) begin
      DivGo     = 1'b1;
      EnF       = 1'b0;
      EnD       = 1'b0;
      EnE       = 1'b0;
      ClrM      = 1'b1;
      state_d   = StDiv;
      div_cnt_d = DivCycles;
    end else if (load_use | br_haz) begin
      EnF  = 1'b0;
      EnD  = 1'b0;
      ClrE = 1'b1;
    end else if (fetch_stall) begin
      EnF  = 1'b0;
      ClrD = 1'b1;
    end

    // Reset freezes and flushes every stage and suppresses divider handshakes.
    if (rst) begin
      EnF      = 1'b0;
      EnD      = 1'b0;
      EnE      = 1'b0;
      EnM      = 1'b0;
      EnW      = 1'b0;
      ClrD     = 1'b1;
      ClrE     = 1'b1;
      ClrM     = 1'b1;
      ClrW     = 1'b1;
      DivGo    = 1'b0;
      DivAbort = 1'b0;
    end
  end

  assign DivBusy = (state_q == StDiv);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      div_cnt_q <= 6'd0;
    end else begin
      state_q   <= state_d;
      div_cnt_q <= div_cnt_d;
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl; output vector order is
// {EnF,EnD,EnE,EnM,EnW, ClrD,ClrE,ClrM,ClrW, DivGo,DivAbort,DivBusy}.
module tb_pipe_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] RsD, RtD, WriteRegE, WriteRegM;
  logic       BranchD, RegWriteE, MemToRegE, MemToRegM, DivStartE;
  logic       InstReqF, InstOkF, DataReqM, DataOkM, ExceptionM;
  logic       EnF, EnD, EnE, EnM, EnW, ClrD, ClrE, ClrM, ClrW, DivGo, DivAbort, DivBusy;

  int vectors = 0;
  int miscompares = 0;

  localparam logic [11:0] VReset   = 12'b00000_1111_000;
  localparam logic [11:0] VRun     = 12'b11111_0000_000;
  localparam logic [11:0] VLoadUse = 12'b00111_0100_000;
  localparam logic [11:0] VFetch   = 12'b01111_1000_000;
  localparam logic [11:0] VDivGo   = 12'b00011_0010_100;
  localparam logic [11:0] VDiv     = 12'b00011_0010_001;
  localparam logic [11:0] VMemDiv  = 12'b00001_0001_001;
  localparam logic [11:0] VMemDone = 12'b00001_0001_000;
  localparam logic [11:0] VExcDiv  = 12'b11111_1110_011;
  localparam logic [11:0] VExcIdle = 12'b11111_1110_000;

  pipe_hazard_ctrl dut (
    .clk(clk), .rst(rst), .RsD(RsD), .RtD(RtD), .BranchD(BranchD),
    .RegWriteE(RegWriteE), .MemToRegE(MemToRegE), .WriteRegE(WriteRegE),
    .MemToRegM(MemToRegM), .WriteRegM(WriteRegM), .DivStartE(DivStartE),
    .InstReqF(InstReqF), .InstOkF(InstOkF), .DataReqM(DataReqM), .DataOkM(DataOkM),
    .ExceptionM(ExceptionM), .EnF(EnF), .EnD(EnD), .EnE(EnE), .EnM(EnM), .EnW(EnW),
    .ClrD(ClrD), .ClrE(ClrE), .ClrM(ClrM), .ClrW(ClrW), .DivGo(DivGo),
    .DivAbort(DivAbort), .DivBusy(DivBusy)
  );

  always #5 clk = ~clk;

  function automatic logic [11:0] outs();
    return {EnF, EnD, EnE, EnM, EnW, ClrD, ClrE, ClrM, ClrW, DivGo, DivAbort, DivBusy};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    RsD = 5'd0; RtD = 5'd0; WriteRegE = 5'd0; WriteRegM = 5'd0;
    BranchD = 1'b0; RegWriteE = 1'b0; MemToRegE = 1'b0; MemToRegM = 1'b0;
    DivStartE = 1'b0; InstReqF = 1'b0; InstOkF = 1'b0; DataReqM = 1'b0;
    DataOkM = 1'b0; ExceptionM = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    clear_inputs();
    #2;
    if (outs() !== VReset) begin
      $display("FAIL reset_idle: got %b want %b", outs(), VReset); miscompares++;
    end
    vectors++;
    DivStartE = 1'b1; MemToRegE = 1'b1; RegWriteE = 1'b1; WriteRegE = 5'd3; RsD = 5'd3;
    #1;
    if (outs() !== VReset) begin
      $display("FAIL reset_masks_inputs: got %b want %b", outs(), VReset); miscompares++;
    end
    vectors++;
    clear_inputs();
    tick();
    rst = 1'b0;
    InstReqF = 1'b1;
    #1;
    if (outs() !== VFetch) begin
      $display("FAIL reset_release_same_cycle: got %b want %b", outs(), VFetch); miscompares++;
    end
    vectors++;
    InstOkF = 1'b1;
    #1;
    if (outs() !== VRun) begin
      $display("FAIL fetch_ok: got %b want %b", outs(), VRun); miscompares++;
    end
    vectors++;
    clear_inputs();
  endtask

  task automatic test_load_use();
    tick();
    MemToRegE = 1'b1; RegWriteE = 1'b1; WriteRegE = 5'd2; RsD = 5'd2; RtD = 5'd9;
    #1;
    if (outs() !== VLoadUse) begin
      $display("FAIL load_use_rs: got %b want %b", outs(), VLoadUse); miscompares++;
    end
    vectors++;
    tick();
    clear_inputs();
    RsD = 5'd2;
    #1;
    if (outs() !== VRun) begin
      $display("FAIL load_use_released: got %b want %b", outs(), VRun); miscompares++;
    end
    vectors++;
    MemToRegE = 1'b1; RegWriteE = 1'b1; WriteRegE = 5'd17; RsD = 5'd4; RtD = 5'd17;
    #1;
    if (outs() !== VLoadUse) begin
      $display("FAIL load_use_rt: got %b want %b", outs(), VLoadUse); miscompares++;
    end
    vectors++;
    WriteRegE = 5'd0; RsD = 5'd0; RtD = 5'd0;
    #1;
    if (outs() !== VRun) begin
      $display("FAIL load_use_r0: got %b want %b", outs(), VRun); miscompares++;
    end
    vectors++;
    RegWriteE = 1'b0; WriteRegE = 5'd6; RsD = 5'd6;
    #1;
    if (outs() !== VRun) begin
      $display("FAIL load_no_regwrite: got %b want %b", outs(), VRun); miscompares++;
    end
    vectors++;
    clear_inputs();
  endtask

  task automatic test_branch();
    tick();
    BranchD = 1'b1; RsD = 5'd0; WriteRegE = 5'd0; RegWriteE = 1'b1;
    #1;
    if (outs() !== VRun) begin
      $display("FAIL branch_r0: got %b want %b", outs(), VRun); miscompares++;
    end
    vectors++;
    InstReqF = 1'b1; InstOkF = 1'b0;
    #1;
    if (outs() !== VFetch) begin
      $display("FAIL branch_fetch_stall: got %b want %b", outs(), VFetch); miscompares++;
    end
    vectors++;
    WriteRegE = 5'd5; RtD = 5'd5;
    #1;
    if (outs() !== VLoadUse) begin
      $display("FAIL branch_alu_over_fetch: got %b want %b", outs(), VLoadUse); miscompares++;
    end
    vectors++;
    InstReqF = 1'b0; RegWriteE = 1'b0; MemToRegM = 1'b1; WriteRegM = 5'd7; RsD = 5'd7;
    RtD = 5'd1;
    #1;
    if (outs() !== VLoadUse) begin
      $display("FAIL branch_mem_load: got %b want %b", outs(), VLoadUse); miscompares++;
    end
    vectors++;
    BranchD = 1'b0;
    #1;
    if (outs() !== VRun) begin
      $display("FAIL nonbranch_mem_load: got %b want %b", outs(), VRun); miscompares++;
    end
    vectors++;
    clear_inputs();
  endtask

  task automatic test_divide();
    tick();
    DivStartE = 1'b1;
    #1;
    if (outs() !== VDivGo) begin
      $display("FAIL div_go: got %b want %b", outs(), VDivGo); miscompares++;
    end
    vectors++;
    for (int i = 1; i <= 32; i++) begin
      tick();
      if (outs() !== VDiv) begin
        $display("FAIL div_cycle_%0d: got %b want %b", i, outs(), VDiv); miscompares++;
      end
      vectors++;
    end
    tick();
    if (outs() !== VRun) begin
      $display("FAIL div_done_no_rego: got %b want %b", outs(), VRun); miscompares++;
    end
    vectors++;
    DivStartE = 1'b0;
    tick();
    if (outs() !== VRun) begin
      $display("FAIL div_back_idle: got %b want %b", outs(), VRun); miscompares++;
    end
    vectors++;
    DivStartE = 1'b1;
    #1;
    if (outs() !== VDivGo) begin
      $display("FAIL div_restart_from_idle: got %b want %b", outs(), VDivGo); miscompares++;
    end
    vectors++;
    ExceptionM = 1'b1;
    #1;
    if (outs() !== VExcIdle) begin
      $display("FAIL exception_beats_divgo: got %b want %b", outs(), VExcIdle); miscompares++;
    end
    vectors++;
    tick();
    clear_inputs();
    #1;
    if (outs() !== VRun) begin
      $display("FAIL exception_idle_stays: got %b want %b", outs(), VRun); miscompares++;
    end
    vectors++;
  endtask

  task automatic test_div_memstall();
    tick();
    DivStartE = 1'b1;
    #1;
    if (outs() !== VDivGo) begin
      $display("FAIL ms_div_go: got %b want %b", outs(), VDivGo); miscompares++;
    end
    vectors++;
    for (int i = 1; i <= 30; i++) tick();
    tick();
    DataReqM = 1'b1; DataOkM = 1'b0;
    #1;
    for (int i = 31; i <= 32; i++) begin
      if (outs() !== VMemDiv) begin
        $display("FAIL ms_div_cycle_%0d: got %b want %b", i, outs(), VMemDiv); miscompares++;
      end
      vectors++;
      tick();
    end
    for (int i = 0; i < 3; i++) begin
      if (outs() !== VMemDone) begin
        $display("FAIL ms_done_hold_%0d: got %b want %b", i, outs(), VMemDone); miscompares++;
      end
      vectors++;
      tick();
    end
    // Still DIV_DONE here, so DivStartE must not trigger a second DivGo.
    DataOkM = 1'b1;
    #1;
    if (outs() !== VRun) begin
      $display("FAIL ms_done_release: got %b want %b", outs(), VRun); miscompares++;
    end
    vectors++;
    tick();
    clear_inputs();
    #1;
    if (outs() !== VRun) begin
      $display("FAIL ms_back_idle: got %b want %b", outs(), VRun); miscompares++;
    end
    vectors++;
  endtask

  task automatic test_div_exception();
    tick();
    DivStartE = 1'b1;
    #1;
    for (int i = 1; i <= 10; i++) tick();
    if (outs() !== VDiv) begin
      $display("FAIL exc_pre_div: got %b want %b", outs(), VDiv); miscompares++;
    end
    vectors++;
    ExceptionM = 1'b1;
    #1;
    if (outs() !== VExcDiv) begin
      $display("FAIL exc_abort: got %b want %b", outs(), VExcDiv); miscompares++;
    end
    vectors++;
    tick();
    clear_inputs();
    #1;
    if (outs() !== VRun) begin
      $display("FAIL exc_idle_next: got %b want %b", outs(), VRun); miscompares++;
    end
    vectors++;
  endtask

  task automatic test_reset_mid_div();
    tick();
    DivStartE = 1'b1;
    #1;
    for (int i = 1; i <= 5; i++) tick();
    rst = 1'b1;
    DivStartE = 1'b0;
    #1;
    if (outs() !== VReset) begin
      $display("FAIL rst_mid_div: got %b want %b", outs(), VReset); miscompares++;
    end
    vectors++;
    tick();
    if (outs() !== VReset) begin
      $display("FAIL rst_mid_div_held: got %b want %b", outs(), VReset); miscompares++;
    end
    vectors++;
    rst = 1'b0;
    #1;
    if (outs() !== VRun) begin
      $display("FAIL rst_release_idle: got %b want %b", outs(), VRun); miscompares++;
    end
    vectors++;
    tick();
    if (outs() !== VRun) begin
      $display("FAIL rst_release_next: got %b want %b", outs(), VRun); miscompares++;
    end
    vectors++;
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_branch();
    test_divide();
    test_div_memstall();
    test_div_exception();
    test_reset_mid_div();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 SHALL have ports: clk in 1, clock; all state changes on its rising edge.
REQ-002 SHALL have port rst in 1; reset is asynchronous and active-high.
REQ-003 SHALL have inputs RsD, RtD in 5 each: source register numbers of the instruction in ID.
REQ-004 SHALL have input BranchD in 1: the ID instruction is a branch or jump-register, resolved in ID.
REQ-005 SHALL have inputs RegWriteE in 1, MemToRegE in 1, WriteRegE in 5: EX-stage destination info.
REQ-006 SHALL have inputs MemToRegM in 1, WriteRegM in 5: MEM-stage destination info.
REQ-007 SHALL have input DivStartE in 1: the EX instruction is DIV or DIVU.
REQ-008 SHALL have inputs InstReqF, InstOkF in 1 each: instruction-fetch request and data valid.
REQ-009 SHALL have inputs DataReqM, DataOkM in 1 each: data-memory request and completion.
REQ-010 SHALL have input ExceptionM in 1: exception or ERET committing in MEM.
REQ-011 SHALL have outputs EnF, EnD, EnE, EnM, EnW out 1 each: load enables for PC, if2id, id2ex, ex2mem and mem2wb.
REQ-012 SHALL have outputs ClrD, ClrE, ClrM, ClrW out 1 each: synchronous clears for the same stage registers.
REQ-013 SHALL have outputs DivGo out 1 (one-cycle divider start), DivAbort out 1 (one-cycle divider kill) and DivBusy out 1.

Function
REQ-014 SHALL implement FSM states IDLE, DIV, DIV_DONE, held with a 6-bit down-counter DivCnt.
REQ-015 SHALL define memStall = DataReqM & ~DataOkM; fetchStall = InstReqF & ~InstOkF.
REQ-016 SHALL define loadUse = MemToRegE & RegWriteE & WriteRegE!=0 & (WriteRegE==RsD | WriteRegE==RtD).
REQ-017 SHALL define brHaz = BranchD & ((RegWriteE & WriteRegE!=0 & WriteRegE matches RsD or RtD) | (MemToRegM & WriteRegM!=0 & WriteRegM matches RsD or RtD)).
REQ-018 SHALL default to all En=1, all Clr=0, then apply only the first matching case below.
REQ-019 Case 1, ExceptionM: ClrD=ClrE=ClrM=1, EnF=1. If state is DIV or DIV_DONE, DivAbort=1, next state IDLE, DivCnt cleared.
REQ-020 Case 2, memStall: EnF=EnD=EnE=EnM=0, ClrW=1. The FSM keeps counting, but DIV_DONE holds.
REQ-021 Case 3, state DIV: EnF=EnD=EnE=0, ClrM=1.
REQ-022 Case 4, state IDLE with DivStartE: DivGo=1, EnF=EnD=EnE=0, ClrM=1, next state DIV, DivCnt=32.
REQ-023 Case 5, loadUse or brHaz: EnF=EnD=0, ClrE=1.
REQ-024 Case 6, fetchStall: EnF=0, ClrD=1.
REQ-025 In DIV, DivCnt SHALL decrement each cycle; at DivCnt==1 the next state SHALL be DIV_DONE.
REQ-026 In DIV_DONE, no stall SHALL be asserted for the divide, and DivStartE SHALL be ignored (same instruction).
REQ-027 DIV_DONE SHALL go to IDLE on the next edge unless memStall holds it.
REQ-028 DivGo SHALL never assert outside IDLE; DivBusy = (state==DIV).
REQ-029 Total divide stall SHALL be 33 cycles, the DivGo cycle plus 32 DIV cycles, excluding memStall extensions.
REQ-030 Register 0 SHALL never create a hazard.

Reset
REQ-031 While rst=1: state=IDLE, DivCnt=0, all En=0, all Clr=1, DivGo=DivAbort=DivBusy=0.
REQ-032 rst asserted mid-divide SHALL abandon it without asserting DivAbort.
REQ-033 After rst falls, outputs SHALL follow REQ-018..024 in the same cycle.

Verification
REQ-034 LW r2 in EX (MemToRegE=1, WriteRegE=2), RsD=2 -> one cycle of EnF=EnD=0, ClrE=1; next cycle all En=1.
REQ-035 DivStartE=1 in IDLE -> DivGo=1 for one cycle, DivBusy=1 for 32 cycles, EnE=0 for 33 cycles.
REQ-035 (cont.) Then DIV_DONE with EnE=1, and no second DivGo although DivStartE is still 1.
REQ-036 DataReqM=1, DataOkM=0 for 5 cycles during DIV cycle 31 -> DIV_DONE held until DataOkM.
REQ-036 (cont.) EnM=0 and ClrW=1 throughout; DivGo not reasserted.
REQ-037 ExceptionM=1 at DIV cycle 10 -> DivAbort=1, ClrD=ClrE=ClrM=1, EnF=1, IDLE next cycle.
REQ-038 BranchD=1, RsD=0, WriteRegE=0, RegWriteE=1 -> no stall. With InstReqF=1, InstOkF=0 -> EnF=0, ClrD=1.
REQ-039 rst pulsed at DIV cycle 5 -> all En=0, Clr=1 during reset; IDLE and DivBusy=0 on release.
